hazard_bubble_ctrl: RTL
=======================

Name: hazard_bubble_ctrl

Overview:
- Parametrised load-use hazard detector and bubble inserter that owns the ID/EX control register of the pipeline.
- Takes the decoded control bundle from ID and registers it into EX, or registers an all-zero bubble into EX.
- Stalls PC and IF/ID for a configurable number of cycles after a load-use hazard.
- Handles branch flush and external (memory-wait) freeze; counts inserted bubbles for performance debug.

Parameters:
- CTRL_W, 11, width of the packed control bundle (ALUOp, RegDst, MemToReg, ALUSrc, MemRead, MemWrite, RegWrite).
- MEMREAD_BIT, 0, bit index of MemRead inside the bundle (0..CTRL_W-1).
- REG_AW, 5, register-address width.
- LOAD_STALL, 1, bubble cycles per load-use hazard (1..7).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ctrl  in  CTRL_W  decoded control bundle of the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source register 1 of the ID instruction.
- id_rt  in  REG_AW  source register 2 of the ID instruction.
- id_uses_rt  in  1  ID instruction reads rt.
- id_dst  in  REG_AW  destination register of the ID instruction.
- flush  in  1  branch/jump redirect; squash ID.
- stall_ext  in  1  external freeze (memory wait).
- ex_ctrl  out  CTRL_W  registered ID/EX control bundle.
- ex_dst  out  REG_AW  registered ID/EX destination register.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- hazard  out  1  load-use hazard detected this cycle (combinational).
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Reset (async, rst_n=0):
  - ex_ctrl=0, ex_dst=0, bubble_cnt=0.
  - FSM=IDLE, remaining-count register=0.
  - Combinational outputs then give pc_write=1, ifid_write=1, hazard=0.
- Hazard detection (combinational):
  - hazard = id_valid & ex_ctrl[MEMREAD_BIT] & (ex_dst!=0) & ((ex_dst==id_rs) | (id_uses_rt & ex_dst==id_rt)).
  - hazard is forced to 0 in STALL state.
- FSM states: IDLE, STALL. A 3-bit remaining-count register is used only in STALL.
- Per-cycle priority: flush > stall_ext > hazard/STALL > normal.
  - flush:
    - ex_ctrl and ex_dst load 0.
    - FSM goes to IDLE and the remaining count clears.
    - pc_write=1, ifid_write=1.
    - No bubble is counted. A hazard in the same cycle is ignored.
  - stall_ext (no flush):
    - ex_ctrl and ex_dst hold.
    - pc_write=0, ifid_write=0.
    - FSM and remaining count hold; no count increment.
  - IDLE with hazard:
    - ex_ctrl and ex_dst load 0 (bubble); pc_write=0, ifid_write=0; bubble_cnt+1.
    - If LOAD_STALL>1, go to STALL with remaining=LOAD_STALL-1; otherwise stay IDLE.
  - STALL:
    - Bubble loaded as above; pc_write=0, ifid_write=0; bubble_cnt+1.
    - remaining decrements by 1; when remaining==1 at the edge, go to IDLE.
  - Normal (IDLE, no hazard):
    - ex_ctrl <= id_valid ? id_ctrl : 0.
    - ex_dst <= id_valid ? id_dst : 0.
    - pc_write=1, ifid_write=1.
- After the last bubble, the load has left EX, so the hazard does not re-fire; the held ID instruction then advances.
- bubble_cnt saturates at all-ones and never wraps.
- Latency:
  - Control reaches EX one cycle after ID.
  - Stall/hazard outputs are same-cycle combinational from registered state and ID inputs.
- Reset asserted mid-stall aborts the stall immediately; outputs return to reset values asynchronously.
- Parameter checks: LOAD_STALL outside 1..7 or MEMREAD_BIT ≥ CTRL_W is a configuration error, flagged by simulation-time check.

Test Plan:
- Basic flow: id_valid=1, id_ctrl=11'h2A4 (MemRead=0), id_dst=5 -> next cycle ex_ctrl=11'h2A4, ex_dst=5; pc_write=1 throughout; bubble_cnt=0.
- Load-use, LOAD_STALL=1: EX holds ex_ctrl=11'h001, ex_dst=8; ID has id_rs=8 -> hazard=1, pc_write=ifid_write=0 for 1 cycle, ex_ctrl=0 next cycle, bubble_cnt=1; following cycle the ID instruction enters EX.
- LOAD_STALL=3, id_uses_rt=1, id_rt=8 matches ex_dst=8 -> exactly 3 bubble cycles with pc_write=0, bubble_cnt=3, then IDLE. Repeat with ex_dst=0 -> no hazard.
- Flush priority: hazard and flush=1 in the same cycle -> ex_ctrl=0, pc_write=1, bubble_cnt unchanged, FSM=IDLE. Flush during STALL (LOAD_STALL=3, 2nd cycle) -> stall aborts.
- stall_ext=1 for 2 cycles during STALL -> ex_ctrl and remaining count frozen, pc_write=0; the stall resumes afterward with a total of 3 bubbles counted.
- Reset/saturation: assert rst_n=0 mid-STALL -> all outputs reset at once. Preload to CNT_W=4, run 20 hazards -> bubble_cnt sticks at 4'hF.

Source files
------------

// File: rtl/hazard_bubble_ctrl.sv
// Load-use hazard detector that owns the ID/EX control register, inserts bubbles,
// stalls PC and IF/ID, and keeps a saturating count of inserted bubbles.
module hazard_bubble_ctrl #(
  parameter int unsigned CTRL_W      = 11,
  parameter int unsigned MEMREAD_BIT = 0,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LOAD_STALL  = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              flush_i,
  input  logic              stall_ext_i,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [REG_AW-1:0] ex_dst_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              hazard_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  if (LOAD_STALL == 0 || LOAD_STALL > 7 || MEMREAD_BIT >= CTRL_W) begin : g_param_err
    $fatal(1, "hazard_bubble_ctrl: LOAD_STALL must be 1..7 and MEMREAD_BIT < CTRL_W");
  end

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  localparam logic [2:0] StallInit = 3'(LOAD_STALL - 1);

  state_e            state_q, state_d;
  logic [2:0]        rem_q, rem_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hazard, cnt_inc, pc_write;

  always_comb begin
    logic rs_match, rt_match;
    rs_match = (ex_dst_q == id_rs_i);
    rt_match = id_uses_rt_i && (ex_dst_q == id_rt_i);
    hazard   = (state_q == StIdle) && id_valid_i && ex_ctrl_q[MEMREAD_BIT] &&
               (ex_dst_q != '0) && (rs_match || rt_match);
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    ex_ctrl_d = ex_ctrl_q;
    ex_dst_d  = ex_dst_q;
    cnt_inc   = 1'b0;
    pc_write  = 1'b1;
    if (flush_i) begin
      ex_ctrl_d = '0;
      ex_dst_d  = '0;
      state_d   = StIdle;
      rem_d     = '0;
    end else if (stall_ext_i) begin
      pc_write = 1'b0;
    end else if (state_q == StStall) begin
      ex_ctrl_d = '0;
      ex_dst_d  = '0;
      pc_write  = 1'b0;
      cnt_inc   = 1'b1;
      rem_d     = rem_q - 3'd1;
      if (rem_q == 3'd1) begin
        state_d = StIdle;
      end
    end else if (hazard) begin
      ex_ctrl_d = '0;
      ex_dst_d  = '0;
      pc_write  = 1'b0;
      cnt_inc   = 1'b1;
      // The hazard cycle is the first bubble; STALL covers the remainder.
      if (LOAD_STALL > 1) begin
        state_d = StStall;
        rem_d   = StallInit;
      end
    end else begin
      ex_ctrl_d = id_valid_i ? id_ctrl_i : '0;
      ex_dst_d  = id_valid_i ? id_dst_i : '0;
    end
    cnt_d = (cnt_inc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      ex_ctrl_q <= '0;
      ex_dst_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      ex_ctrl_q <= ex_ctrl_d;
      ex_dst_q  <= ex_dst_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_ctrl_o    = ex_ctrl_q;
  assign ex_dst_o     = ex_dst_q;
  assign pc_write_o   = pc_write;
  assign ifid_write_o = pc_write;
  assign hazard_o     = hazard;
  assign bubble_cnt_o = cnt_q;

endmodule
